// File: rtl/icache_refill_responder_if.sv
// Bundle of the miss-request, backing-store and replacement-word signals of the
// L1 instruction-cache refill responder.
interface icache_refill_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  miss_req_i;
  logic [ADDR_WIDTH-1:0] miss_addr_i;
  logic                  flush_i;
  logic                  mem_rd_en_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [63:0]           mem_rdata_i;
  logic                  RepReady;
  logic [63:0]           RepWord;
  logic                  rep_last_o;
  logic                  busy_o;

  modport slave (
    input  miss_req_i, miss_addr_i, flush_i, mem_rdata_i,
    output mem_rd_en_o, mem_addr_o, RepReady, RepWord, rep_last_o, busy_o
  );

  modport master (
    output miss_req_i, miss_addr_i, flush_i, mem_rdata_i,
    input  mem_rd_en_o, mem_addr_o, RepReady, RepWord, rep_last_o, busy_o
  );
endinterface

// File: rtl/icache_refill_responder.sv
// Critical-word-first line refill: waits LATENCY cycles, streams LINE_WORDS reads
// wrapping within the line, and presents each returned word one cycle later.
module icache_refill_responder #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic                      clk_i,
  input logic                      reset_i,
  icache_refill_responder_if.slave bus
);

  localparam int unsigned OFF  = $clog2(LINE_WORDS * 8);
  localparam int unsigned IDXW = $clog2(LINE_WORDS);
  localparam int unsigned WCW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned HIW  = ADDR_WIDTH - OFF;

  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(LATENCY - 1);
  localparam logic [IDXW-1:0] WORD_LAST = IDXW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, READ, DRAIN} state_t;

  state_t                state;
  logic [WCW-1:0]        wait_cnt;
  logic [IDXW-1:0]       word_cnt;
  logic [IDXW-1:0]       rd_idx;
  logic [HIW-1:0]        base_hi;
  logic                  mem_rd_en_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_last_q;
  logic                  rd_valid_q;
  logic                  rd_last_q;
  logic                  rep_ready_q;
  logic [63:0]           rep_word_q;
  logic                  rep_last_q;

  logic [IDXW-1:0]       next_idx;
  logic [IDXW-1:0]       next_cnt;
  logic                  unused_addr_lsbs;

  // Index arithmetic wraps at IDXW bits, i.e. modulo LINE_WORDS.
  always_comb begin
    next_idx = rd_idx + 1'b1;
    next_cnt = word_cnt + 1'b1;
  end

  assign unused_addr_lsbs = ^bus.miss_addr_i[2:0];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      word_cnt    <= '0;
      rd_idx      <= '0;
      base_hi     <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_last_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rep_ready_q <= 1'b0;
      rep_word_q  <= '0;
      rep_last_q  <= 1'b0;
    end else if (bus.flush_i) begin
      // Abort: drop reads in flight; RepWord keeps its last presented value.
      state       <= IDLE;
      wait_cnt    <= '0;
      word_cnt    <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_last_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rep_ready_q <= 1'b0;
      rep_last_q  <= 1'b0;
    end else begin
      rd_valid_q  <= mem_rd_en_q;
      rd_last_q   <= mem_rd_en_q & mem_last_q;
      rep_ready_q <= rd_valid_q;
      rep_last_q  <= rd_valid_q & rd_last_q;
      if (rd_valid_q) begin
        rep_word_q <= bus.mem_rdata_i;
      end

      case (state)
        IDLE: begin
          if (bus.miss_req_i) begin
            base_hi  <= bus.miss_addr_i[ADDR_WIDTH-1:OFF];
            rd_idx   <= bus.miss_addr_i[OFF-1:3];
            wait_cnt <= '0;
            word_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt    <= '0;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= {base_hi, rd_idx, 3'b000};
            mem_last_q  <= 1'b0;
            state       <= READ;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        READ: begin
          if (word_cnt == WORD_LAST) begin
            word_cnt    <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_last_q  <= 1'b0;
            state       <= DRAIN;
          end else begin
            word_cnt    <= next_cnt;
            rd_idx      <= next_idx;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= {base_hi, next_idx, 3'b000};
            mem_last_q  <= (next_cnt == WORD_LAST);
          end
        end
        DRAIN: begin
          if (rep_last_q) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en_o = mem_rd_en_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.RepReady    = rep_ready_q;
  assign bus.RepWord     = rep_word_q;
  assign bus.rep_last_o  = rep_last_q;
  assign bus.busy_o      = (state != IDLE);

endmodule

// File: tb/tb_icache_refill_responder.sv
// Directed bench for icache_refill_responder (LINE_WORDS=4, LATENCY=3) with a
// backing store that returns {32'h0, addr} one cycle after each read strobe.
module tb_icache_refill_responder;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  logic [63:0] last_word;

  icache_refill_responder_if #(.ADDR_WIDTH(32)) bus ();

  icache_refill_responder #(
    .LINE_WORDS(4),
    .LATENCY(3),
    .ADDR_WIDTH(32)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rd_en_o) bus.mem_rdata_i <= {32'h0, bus.mem_addr_o};
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [63:0] word);
    check_val({tag, " busy"},  {63'h0, bus.busy_o}, 64'h0);
    check_val({tag, " rd_en"}, {63'h0, bus.mem_rd_en_o}, 64'h0);
    check_val({tag, " addr"},  {32'h0, bus.mem_addr_o}, 64'h0);
    check_val({tag, " ready"}, {63'h0, bus.RepReady}, 64'h0);
    check_val({tag, " last"},  {63'h0, bus.rep_last_o}, 64'h0);
    check_val({tag, " word"},  bus.RepWord, word);
  endtask

  // Caller raises miss_req_i/miss_addr_i beforehand; next rising edge is E0.
  // Checks every output from E0 through E9 against the expected word order.
  task automatic check_fill(input string tag, input logic [63:0] w0, input logic [63:0] w1,
                            input logic [63:0] w2, input logic [63:0] w3,
                            input bit hold, input logic [31:0] next_addr);
    logic [63:0] w [4];
    logic        e_en, e_rdy, e_last, e_busy;
    logic [63:0] e_addr, e_word;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    @(posedge clk);
    #1;
    if (hold) bus.miss_addr_i = next_addr;
    else      bus.miss_req_i  = 1'b0;
    for (int i = 0; i <= 9; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      e_en   = (i >= 3 && i <= 6);
      e_addr = e_en ? w[i-3] : 64'h0;
      e_rdy  = (i >= 5 && i <= 8);
      e_word = e_rdy ? w[i-5] : ((i < 5) ? last_word : w[3]);
      e_last = (i == 8);
      e_busy = (i <= 8);
      check_val($sformatf("%s E%0d rd_en", tag, i), {63'h0, bus.mem_rd_en_o}, {63'h0, e_en});
      check_val($sformatf("%s E%0d addr", tag, i),  {32'h0, bus.mem_addr_o}, e_addr);
      check_val($sformatf("%s E%0d ready", tag, i), {63'h0, bus.RepReady}, {63'h0, e_rdy});
      check_val($sformatf("%s E%0d word", tag, i),  bus.RepWord, e_word);
      check_val($sformatf("%s E%0d last", tag, i),  {63'h0, bus.rep_last_o}, {63'h0, e_last});
      check_val($sformatf("%s E%0d busy", tag, i),  {63'h0, bus.busy_o}, {63'h0, e_busy});
    end
    last_word = w[3];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total = 0;
    n_bad = 0;
    last_word = 64'h0;
    rst_n = 1'b0;
    bus.miss_req_i  = 1'b0;
    bus.miss_addr_i = '0;
    bus.flush_i     = 1'b0;
    bus.mem_rdata_i = '0;

    // Reset state, with a request pending that must not be taken.
    bus.miss_req_i  = 1'b1;
    bus.miss_addr_i = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset", 64'h0);
    bus.miss_req_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Flush and request together in IDLE: flush wins.
    @(negedge clk);
    bus.flush_i     = 1'b1;
    bus.miss_req_i  = 1'b1;
    bus.miss_addr_i = 32'h100;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("flush+req", 64'h0);
    bus.flush_i = 1'b0;

    // Aligned miss, request still high from above.
    check_fill("aligned", 64'h100, 64'h108, 64'h110, 64'h118, 1'b0, 32'h0);

    // Flush sampled at E6: only word 0 gets presented.
    @(negedge clk);
    bus.miss_req_i  = 1'b1;
    bus.miss_addr_i = 32'h100;
    @(posedge clk);
    #1 bus.miss_req_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_val("flush E5 ready", {63'h0, bus.RepReady}, 64'h1);
    check_val("flush E5 word", bus.RepWord, 64'h100);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    @(negedge clk);
    check_idle_outputs("flush E6", 64'h100);
    for (int i = 7; i <= 9; i++) begin
      @(negedge clk);
      check_val($sformatf("flush E%0d ready", i), {63'h0, bus.RepReady}, 64'h0);
      check_val($sformatf("flush E%0d word", i), bus.RepWord, 64'h100);
    end
    last_word = 64'h100;

    // Unaligned miss after the flush: critical word first, wrapping.
    bus.miss_req_i  = 1'b1;
    bus.miss_addr_i = 32'h114;
    check_fill("wrap114", 64'h110, 64'h118, 64'h100, 64'h108, 1'b0, 32'h0);

    // Reset mid-fill after E4, released two cycles later.
    @(negedge clk);
    bus.miss_req_i  = 1'b1;
    bus.miss_addr_i = 32'h100;
    @(posedge clk);
    #1 bus.miss_req_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset", 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val($sformatf("post-reset c%0d ready", i), {63'h0, bus.RepReady}, 64'h0);
      check_val($sformatf("post-reset c%0d busy", i), {63'h0, bus.busy_o}, 64'h0);
    end
    last_word = 64'h0;

    bus.miss_req_i  = 1'b1;
    bus.miss_addr_i = 32'h118;
    check_fill("wrap118", 64'h118, 64'h100, 64'h108, 64'h110, 1'b0, 32'h0);

    // Request held high: second fill accepted on the edge after IDLE is entered.
    @(negedge clk);
    bus.miss_req_i  = 1'b1;
    bus.miss_addr_i = 32'h200;
    check_fill("held200", 64'h200, 64'h208, 64'h210, 64'h218, 1'b1, 32'h300);
    check_fill("held300", 64'h300, 64'h308, 64'h310, 64'h318, 1'b0, 32'h0);

    repeat (2) @(negedge clk);
    check_idle_outputs("final", 64'h318);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
